// File: rtl/traffic_monitor_if.sv
// Harness <-> traffic monitor bundle: start, flit-valid vectors and error in; phase and statistics out.
// port_ej_count exists only when TRAFFIC_MON_PER_PORT_EN is defined.
interface traffic_monitor_if #(
  parameter int num_ports      = 5,
  parameter int count_width    = 32,
  parameter int inflight_width = 16
);
  logic                        start;
  logic [num_ports-1:0]        flit_valid_in_ip;
  logic [num_ports-1:0]        flit_valid_out_op;
  logic                        error_in;
  logic                        run;
  logic [2:0]                  state;
  logic                        done;
  logic [count_width-1:0]      inj_count;
  logic [count_width-1:0]      ej_count;
  logic [count_width-1:0]      meas_cycles;
  logic [inflight_width-1:0]   in_flight;
  logic                        error_flag;
  logic                        timeout_flag;
`ifdef TRAFFIC_MON_PER_PORT_EN
  logic [num_ports*count_width-1:0] port_ej_count;
`endif

  modport master (
    output start, flit_valid_in_ip, flit_valid_out_op, error_in,
    input  run, state, done, inj_count, ej_count, meas_cycles, in_flight,
           error_flag, timeout_flag
`ifdef TRAFFIC_MON_PER_PORT_EN
    , input port_ej_count
`endif
  );

  modport slave (
    input  start, flit_valid_in_ip, flit_valid_out_op, error_in,
    output run, state, done, inj_count, ej_count, meas_cycles, in_flight,
           error_flag, timeout_flag
`ifdef TRAFFIC_MON_PER_PORT_EN
    , output port_ej_count
`endif
  );
endinterface

// File: rtl/traffic_monitor.sv
// Run-phase sequencer and flit statistics for the router harness (IDLE/WARMUP/MEASURE/DRAIN/DONE).
// Define TRAFFIC_MON_PER_PORT_EN to add per-output-port ejection counters (port_ej_count).
module traffic_monitor #(
  parameter int num_ports      = 5,
  parameter int warmup_time    = 100,
  parameter int measure_time   = 10000,
  parameter int drain_timeout  = 1000,
  parameter int count_width    = 32,
  parameter int inflight_width = 16,
  parameter bit abort_on_error = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  traffic_monitor_if.slave mon
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    MEASURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int pc_width = $clog2(num_ports + 1);
  localparam int iw       = inflight_width;
  localparam logic [count_width-1:0] warmup_last  = count_width'(warmup_time - 1);
  localparam logic [count_width-1:0] measure_last = count_width'(measure_time - 1);
  localparam logic [count_width-1:0] drain_last   = count_width'(drain_timeout - 1);

  state_t                 state_reg, state_next;
  logic [count_width-1:0] phase_cnt_reg;
  logic                   run_reg, done_reg;
  logic [count_width-1:0] inj_count_reg, ej_count_reg, meas_cycles_reg;
  logic [iw-1:0]          in_flight_reg;
  logic                   error_flag_reg, timeout_flag_reg;

  logic [pc_width-1:0]    pop_in, pop_out;
  logic [count_width:0]   inj_sum, ej_sum;
  logic [count_width-1:0] inj_sat, ej_sat, meas_sat;
  logic [iw+1:0]          flight_sum;
  logic                   flight_neg, flight_ovf;
  logic [iw-1:0]          flight_clamped;
  logic                   start_clear, abort, count_en, drain_timeout_hit;

  always_comb begin
    pop_in  = '0;
    pop_out = '0;
    for (int i = 0; i < num_ports; i++) begin
      pop_in  = pop_in  + pc_width'(mon.flit_valid_in_ip[i]);
      pop_out = pop_out + pc_width'(mon.flit_valid_out_op[i]);
    end
  end

  assign start_clear = mon.start && (state_reg == IDLE || state_reg == DONE);
  assign abort       = abort_on_error && mon.error_in &&
                       (state_reg == WARMUP || state_reg == MEASURE);
  // The aborting cycle itself is not accumulated: counts freeze at what preceded the error.
  assign count_en    = (state_reg == MEASURE) && !abort;
  assign drain_timeout_hit = (state_reg == DRAIN) && (in_flight_reg != '0) &&
                             (phase_cnt_reg == drain_last);

  assign inj_sum  = {1'b0, inj_count_reg} + (count_width+1)'(pop_in);
  assign ej_sum   = {1'b0, ej_count_reg}  + (count_width+1)'(pop_out);
  assign inj_sat  = inj_sum[count_width] ? '1 : inj_sum[count_width-1:0];
  assign ej_sat   = ej_sum[count_width]  ? '1 : ej_sum[count_width-1:0];
  assign meas_sat = (&meas_cycles_reg) ? meas_cycles_reg : meas_cycles_reg + 1'b1;

  // Two's-complement net change with a guard bit above the sign: MSB marks negative,
  // the next bit marks overflow past the in-flight range.
  assign flight_sum = {2'b00, in_flight_reg} + (iw+2)'(pop_in) - (iw+2)'(pop_out);
  assign flight_neg = flight_sum[iw+1];
  assign flight_ovf = !flight_sum[iw+1] && flight_sum[iw];
  assign flight_clamped = flight_neg ? '0 : (flight_ovf ? '1 : flight_sum[iw-1:0]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (mon.start) state_next = WARMUP;
      WARMUP:     if (abort) state_next = DRAIN;
                  else if (phase_cnt_reg == warmup_last) state_next = MEASURE;
      MEASURE:    if (abort || phase_cnt_reg == measure_last) state_next = DRAIN;
      DRAIN:      if (in_flight_reg == '0 || phase_cnt_reg == drain_last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      phase_cnt_reg    <= '0;
      run_reg          <= 1'b0;
      done_reg         <= 1'b0;
      inj_count_reg    <= '0;
      ej_count_reg     <= '0;
      meas_cycles_reg  <= '0;
      in_flight_reg    <= '0;
      error_flag_reg   <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= (state_next == WARMUP) || (state_next == MEASURE);
      done_reg      <= (state_next == DONE);
      phase_cnt_reg <= (state_next != state_reg) ? '0 : phase_cnt_reg + 1'b1;
      if (start_clear) begin
        inj_count_reg    <= '0;
        ej_count_reg     <= '0;
        meas_cycles_reg  <= '0;
        in_flight_reg    <= '0;
        error_flag_reg   <= 1'b0;
        timeout_flag_reg <= 1'b0;
      end else begin
        if (count_en) begin
          inj_count_reg   <= inj_sat;
          ej_count_reg    <= ej_sat;
          meas_cycles_reg <= meas_sat;
        end
        if (state_reg != IDLE) begin
          in_flight_reg <= flight_clamped;
          if (flight_neg || flight_ovf || mon.error_in) error_flag_reg <= 1'b1;
        end
        if (drain_timeout_hit) timeout_flag_reg <= 1'b1;
      end
    end
  end

  assign mon.run          = run_reg;
  assign mon.state        = state_reg;
  assign mon.done         = done_reg;
  assign mon.inj_count    = inj_count_reg;
  assign mon.ej_count     = ej_count_reg;
  assign mon.meas_cycles  = meas_cycles_reg;
  assign mon.in_flight    = in_flight_reg;
  assign mon.error_flag   = error_flag_reg;
  assign mon.timeout_flag = timeout_flag_reg;

`ifdef TRAFFIC_MON_PER_PORT_EN
  logic [num_ports*count_width-1:0] port_ej_flat;

  // Port 0 occupies the most significant field.
  for (genvar gi = 0; gi < num_ports; gi++) begin : g_port
    logic [count_width-1:0] port_cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        port_cnt_reg <= '0;
      else if (start_clear)
        port_cnt_reg <= '0;
      else if (count_en && mon.flit_valid_out_op[gi] && !(&port_cnt_reg))
        port_cnt_reg <= port_cnt_reg + 1'b1;
    end
    assign port_ej_flat[(num_ports-gi)*count_width-1 -: count_width] = port_cnt_reg;
  end

  assign mon.port_ej_count = port_ej_flat;
`endif
endmodule
